comparatore_soglia: RTL and testbench

Threshold detector that sits directly downstream of the N-bit binary up counter and consumes its `numero` output. A threshold is loaded through a valid/ready handshake. The block then signals the cycle in which the count reaches that threshold, holding the event until it is acknowledged. It also keeps a saturating tally of detected hits for the control unit.

---
 rtl/comparatore_soglia.sv | 124 ++++++++++++
 tb/tb_comparatore_soglia.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/comparatore_soglia.sv
// Threshold detector fed by the up counter's numero: fires evento when the count equals the
// loaded threshold and keeps a saturating hit tally. Optional macro CMP_RIARMO_EN enables auto re-arm.
module comparatore_soglia #(
    parameter int N = 10,
    parameter int H = 4
) (
    input  logic         clock,
    input  logic         reset_,
    input  logic [N-1:0] numero,
    input  logic [N-1:0] soglia_in,
    input  logic         load_valid,
    output logic         load_ready,
    output logic         evento,
    input  logic         ack,
    input  logic         azzera,
    output logic [H-1:0] hit_count,
    output logic         sat,
    output logic [1:0]   stato_dbg
);

    // Load handshake: a threshold is taken on the edge where load_valid and load_ready are both 1.
    // load_ready is combinational and drops in the cycle a match is seen, so a match always wins.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        HIT   = 2'd2
`ifdef CMP_RIARMO_EN
        ,
        REARM = 2'd3
`endif
    } stato_t;

    localparam logic [H-1:0] HIT_MAX = '1;

    stato_t       stato_q, stato_d;
    logic [N-1:0] soglia_q, soglia_d;
    logic         evento_q, evento_d;
    logic [H-1:0] hit_count_q, hit_count_d;
    logic         sat_q, sat_d;

    logic match;
    logic handshake;

    always_comb begin
        match      = (stato_q == ARMED) && (numero == soglia_q);
        load_ready = ((stato_q == IDLE) || (stato_q == ARMED)) && !match;
        handshake  = load_valid && load_ready;
    end

    always_comb begin
        stato_d  = stato_q;
        soglia_d = soglia_q;
        case (stato_q)
            IDLE: begin
                if (handshake) begin
                    soglia_d = soglia_in;
                    stato_d  = ARMED;
                end
            end
            ARMED: begin
                if (match) begin
                    stato_d = HIT;
                end else if (handshake) begin
                    soglia_d = soglia_in;
                end
            end
            HIT: begin
                if (ack) begin
`ifdef CMP_RIARMO_EN
                    stato_d = REARM;
`else
                    stato_d = IDLE;
`endif
                end
            end
`ifdef CMP_RIARMO_EN
            // Hold off until the counter moves away, so a parked counter cannot re-fire.
            REARM: begin
                if (numero != soglia_q) begin
                    stato_d = ARMED;
                end
            end
`endif
            default: begin
                stato_d = IDLE;
            end
        endcase
    end

    always_comb begin
        hit_count_d = hit_count_q;
        if (azzera) begin
            hit_count_d = '0;
        end else if (match && (hit_count_q != HIT_MAX)) begin
            hit_count_d = hit_count_q + 1'b1;
        end
        sat_d    = (hit_count_d == HIT_MAX);
        evento_d = (stato_d == HIT);
    end

    always_ff @(posedge clock) begin
        if (reset_) begin
            stato_q     <= IDLE;
            soglia_q    <= '0;
            evento_q    <= 1'b0;
            hit_count_q <= '0;
            sat_q       <= 1'b0;
        end else begin
            stato_q     <= stato_d;
            soglia_q    <= soglia_d;
            evento_q    <= evento_d;
            hit_count_q <= hit_count_d;
            sat_q       <= sat_d;
        end
    end

    always_comb begin
        evento    = evento_q;
        hit_count = hit_count_q;
        sat       = sat_q;
        stato_dbg = stato_q;
    end

endmodule

// File: tb/tb_comparatore_soglia.sv
// Bench for comparatore_soglia: directed scenarios followed by randomized traffic, all checked
// against a behavioural model of the threshold/event/tally rules.
module tb_comparatore_soglia;

    localparam int N = 10;
    localparam int H = 2;
    localparam int W = H + 2;
    localparam int HMAX = (1 << H) - 1;

    localparam int F_IDLE  = 0;
    localparam int F_ARMED = 1;
    localparam int F_HIT   = 2;
    localparam int F_REARM = 3;

    logic         clock;
    logic         reset_;
    logic [N-1:0] numero;
    logic [N-1:0] soglia_in;
    logic         load_valid;
    logic         load_ready;
    logic         evento;
    logic         ack;
    logic         azzera;
    logic [H-1:0] hit_count;
    logic         sat;
    logic [1:0]   stato_dbg;

    comparatore_soglia #(.N(N), .H(H)) dut (
        .clock     (clock),
        .reset_    (reset_),
        .numero    (numero),
        .soglia_in (soglia_in),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .evento    (evento),
        .ack       (ack),
        .azzera    (azzera),
        .hit_count (hit_count),
        .sat       (sat),
        .stato_dbg (stato_dbg)
    );

    // clock / reset block
    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // Reference model: phase, stored threshold, tally.
    int fase;
    int thr;
    int tally;
    logic [W-1:0] exp_q[$];

`ifdef CMP_RIARMO_EN
    localparam bit RIARMO = 1'b1;
`else
    localparam bit RIARMO = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_ready();
        if (fase == F_IDLE) return 1'b1;
        if (fase == F_ARMED) return (int'(numero) != thr);
        return 1'b0;
    endfunction

    task automatic model_edge();
        bit hit_now;
        bit load_ok;
        hit_now = (fase == F_ARMED) && (int'(numero) == thr);
        load_ok = model_ready() && load_valid;
        if (reset_) begin
            fase  = F_IDLE;
            thr   = 0;
            tally = 0;
        end else begin
            case (fase)
                F_IDLE:  if (load_ok) begin thr = int'(soglia_in); fase = F_ARMED; end
                F_ARMED: if (hit_now) fase = F_HIT;
                         else if (load_ok) thr = int'(soglia_in);
                F_HIT:   if (ack) fase = RIARMO ? F_REARM : F_IDLE;
                default: if (int'(numero) != thr) fase = F_ARMED;
            endcase
            if (azzera) tally = 0;
            else if (hit_now && tally < HMAX) tally = tally + 1;
        end
        exp_q.push_back({(fase == F_HIT), (tally == HMAX), H'(tally)});
    endtask

    // driver: apply one cycle of inputs, check load_ready before the edge, outputs after it
    task automatic step(input int num, input logic lv, input int sin,
                        input logic a, input logic az, input logic r);
        logic [W-1:0] e;
        numero     = N'(num);
        load_valid = lv;
        soglia_in  = N'(sin);
        ack        = a;
        azzera     = az;
        reset_     = r;
        #1;
        check("load_ready", {31'b0, load_ready}, {31'b0, model_ready()});
        @(posedge clock);
        model_edge();
        #1;
        e = exp_q.pop_front();
        check("evento", {31'b0, evento}, {31'b0, e[W-1]});
        check("sat", {31'b0, sat}, {31'b0, e[W-2]});
        check("hit_count", 32'(hit_count), 32'(e[H-1:0]));
    endtask

    task automatic run(input int start, input int cycles);
        for (int i = 0; i < cycles; i++) step((start + i) % (1 << N), 1'b0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic load(input int num, input int value);
        step(num, 1'b1, value, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_ack(input int num);
        step(num, 1'b0, 0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        fase = F_IDLE; thr = 0; tally = 0;
        numero = '0; soglia_in = '0; load_valid = 1'b0; ack = 1'b0; azzera = 1'b0; reset_ = 1'b1;
        @(posedge clock);
        #1;

        // reset held two cycles with a load request present
        step(0, 1'b1, 5, 1'b0, 1'b0, 1'b1);
        step(0, 1'b1, 5, 1'b0, 1'b0, 1'b1);
        check("reset_ready", {31'b0, load_ready}, 32'd1);

        // single hit at threshold 5, held until ack
        load(0, 5);
        run(1, 5);
        check("single_evento", {31'b0, evento}, 32'd1);
        check("single_count", 32'(hit_count), 32'd1);
        run(6, 3);
        do_ack(9);
        run(10, 2);

        // wrap: threshold 0 with the counter starting near the top
        load(1019, 0);
        run(1020, 5);
        check("wrap_evento", {31'b0, evento}, 32'd1);
        do_ack(1);

        // match and load on the same edge: match wins, threshold stays 7
        load(2, 7);
        run(3, 4);
        step(7, 1'b1, 9, 1'b0, 1'b0, 1'b0);
        check("simul_evento", {31'b0, evento}, 32'd1);
        check("simul_sat", {31'b0, sat}, 32'd1);
        do_ack(8);

        // fourth hit: tally stays saturated
        load(9, 12);
        run(10, 4);
        check("sat_hold", 32'(hit_count), 32'd3);
        do_ack(14);

        // fifth hit coincides with azzera: clear wins
        load(15, 20);
        run(16, 4);
        step(20, 1'b0, 0, 1'b0, 1'b1, 1'b0);
        check("clr_count", 32'(hit_count), 32'd0);
        check("clr_evento", {31'b0, evento}, 32'd1);

        // reset while evento is high
        step(21, 1'b0, 0, 1'b0, 1'b0, 1'b1);
        check("rst_evento", {31'b0, evento}, 32'd0);

`ifdef CMP_RIARMO_EN
        // re-arm: counter parked at threshold must not re-fire
        load(0, 3);
        run(1, 3);
        for (int i = 0; i < 4; i++) step(3, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        do_ack(3);
        for (int i = 0; i < 4; i++) step(3, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        check("rearm_quiet", {31'b0, evento}, 32'd0);
        run(1020, 8);
        check("rearm_count", 32'(hit_count), 32'd2);
`endif

        // randomized traffic on a small count range so hits are frequent
        begin
            int cnt;
            cnt = 0;
            for (int i = 0; i < 1500; i++) begin
                logic lv, a, az, r;
                if ($urandom_range(0, 7) == 0) cnt = $urandom_range(0, (1 << N) - 1);
                else if ($urandom_range(0, 3) != 0) cnt = (cnt + 1) % 16;
                lv = ($urandom_range(0, 3) == 0);
                a  = ($urandom_range(0, 4) == 0);
                az = ($urandom_range(0, 30) == 0);
                r  = ($urandom_range(0, 80) == 0);
                step(cnt, lv, $urandom_range(0, 15), a, az, r);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
